rom_ctrl_msg_sink: RTL

Consumer end of the ROM checker's data handshake. It accepts ROM words from the read counter on a valid/ready interface and forwards every non-top word to the KMAC message interface as a 64-bit beat with byte strobes, marking the last non-top word as the final beat. It then captures the `RomTopCount` top words as the expected digest for the checker FSM's comparison.

---
 rtl/rom_ctrl_msg_sink_if.sv | 31 +++
 rtl/rom_ctrl_msg_sink.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rom_ctrl_msg_sink_if.sv
// Handshake bundle between the ROM read counter, the message sink and KMAC.
// The master modport is the environment side; the slave modport is the sink.
interface rom_ctrl_msg_sink_if #(
   parameter int unsigned DataWidth   = 39,
   parameter int unsigned RomTopCount = 8
);
   logic                          data_vld_i;
   logic [DataWidth-1:0]          rom_data_i;
   logic                          data_last_nontop_i;
   logic                          data_rdy_o;
   logic                          kmac_valid_o;
   logic [63:0]                   kmac_data_o;
   logic [7:0]                    kmac_strb_o;
   logic                          kmac_last_o;
   logic                          kmac_ready_i;
   logic [32*RomTopCount-1:0]     exp_digest_o;
   logic                          exp_vld_o;
   logic                          err_o;

   modport master (
      output data_vld_i, rom_data_i, data_last_nontop_i, kmac_ready_i,
      input  data_rdy_o, kmac_valid_o, kmac_data_o, kmac_strb_o, kmac_last_o,
             exp_digest_o, exp_vld_o, err_o
   );

   modport slave (
      input  data_vld_i, rom_data_i, data_last_nontop_i, kmac_ready_i,
      output data_rdy_o, kmac_valid_o, kmac_data_o, kmac_strb_o, kmac_last_o,
             exp_digest_o, exp_vld_o, err_o
   );
endinterface

// File: rtl/rom_ctrl_msg_sink.sv
// Forwards non-top ROM words to KMAC as 64-bit beats, then captures the top words as the expected digest.
// Optional protocol error detection is built when ROM_CTRL_MSG_SINK_ERR_EN is defined.
module rom_ctrl_msg_sink #(
   parameter int unsigned DataWidth   = 39,
   parameter int unsigned RomTopCount = 8
) (
   input logic               clk_i,
   input logic               rst_ni,
   rom_ctrl_msg_sink_if.slave bus
);
   localparam int unsigned IdxW      = (RomTopCount > 1) ? $clog2(RomTopCount) : 1;
   localparam int unsigned DigestW   = 32 * RomTopCount;
   localparam int unsigned StrbBytes = (DataWidth + 7) / 8;
   localparam logic [7:0]  StrbVal   = 8'((32'd1 << StrbBytes) - 32'd1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(RomTopCount - 1);

   typedef enum logic [1:0] {StMsg, StDrain, StTop, StDone} state_e;

   state_e              state_q, state_d;
   logic                kmac_valid_q, kmac_valid_d;
   logic [63:0]         kmac_data_q, kmac_data_d;
   logic                kmac_last_q, kmac_last_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [DigestW-1:0]  digest_q, digest_d;
   logic                exp_vld_q, exp_vld_d;
   logic                data_rdy;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= StMsg;
         kmac_valid_q <= 1'b0;
         kmac_data_q  <= '0;
         kmac_last_q  <= 1'b0;
         idx_q        <= '0;
         digest_q     <= '0;
         exp_vld_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         kmac_valid_q <= kmac_valid_d;
         kmac_data_q  <= kmac_data_d;
         kmac_last_q  <= kmac_last_d;
         idx_q        <= idx_d;
         digest_q     <= digest_d;
         exp_vld_q    <= exp_vld_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      kmac_valid_d = kmac_valid_q;
      kmac_data_d  = kmac_data_q;
      kmac_last_d  = kmac_last_q;
      idx_d        = idx_q;
      digest_d     = digest_q;
      exp_vld_d    = exp_vld_q;
      data_rdy     = 1'b0;
      case (state_q)
         StMsg: begin
            // Single-entry output register: refill allowed in the same cycle KMAC drains it.
            data_rdy = ~kmac_valid_q | bus.kmac_ready_i;
            if (bus.data_vld_i && data_rdy) begin
               kmac_valid_d = 1'b1;
               kmac_data_d  = 64'(bus.rom_data_i);
               kmac_last_d  = bus.data_last_nontop_i;
               if (bus.data_last_nontop_i) state_d = StDrain;
            end else if (bus.kmac_ready_i) begin
               kmac_valid_d = 1'b0;
               kmac_last_d  = 1'b0;
            end
         end
         StDrain: begin
            if (bus.kmac_ready_i) begin
               kmac_valid_d = 1'b0;
               kmac_last_d  = 1'b0;
               state_d      = StTop;
            end
         end
         StTop: begin
            data_rdy = 1'b1;
            if (bus.data_vld_i) begin
               digest_d[32*32'(idx_q) +: 32] = bus.rom_data_i[31:0];
               if (idx_q == LastIdx) begin
                  state_d   = StDone;
                  exp_vld_d = 1'b1;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end
         default: ;
      endcase
   end

`ifdef ROM_CTRL_MSG_SINK_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q
            | (bus.data_vld_i & (state_q == StDone))
            | (bus.data_vld_i & bus.data_last_nontop_i & (state_q == StTop))
            | (kmac_valid_q & ~kmac_valid_d & ~bus.kmac_ready_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) err_q <= 1'b0;
      else         err_q <= err_d;
   end

   assign bus.err_o = err_q;
`else
   assign bus.err_o = 1'b0;
`endif

   assign bus.data_rdy_o   = data_rdy;
   assign bus.kmac_valid_o = kmac_valid_q;
   assign bus.kmac_data_o  = kmac_data_q;
   assign bus.kmac_strb_o  = kmac_valid_q ? StrbVal : 8'h00;
   assign bus.kmac_last_o  = kmac_last_q;
   assign bus.exp_digest_o = digest_q;
   assign bus.exp_vld_o    = exp_vld_q;
endmodule
